// File: rtl/cpe_pilot_accum.sv
// Pilot accumulator: sums the four pilot-bin products of each OFDM symbol into a CPE vector.
// Latency: cpe_valid pulses 1 clk after the last bin (idx N-1) of a symbol is accepted.
// Backpressure: none; every in_en sample is consumed, in_en=0 gaps simply freeze the state.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_en             product valid; in_r/in_i signed Q-bit product
//   sym_start         marks bin 0 of a symbol (only meaningful with in_en=1)
//   cpe_r/cpe_i       signed ACC_W-bit pilot sum, held between pulses
//   cpe_valid         one-cycle pulse when cpe_r/cpe_i are updated
//   sync_err          one-cycle pulse when a symbol is aborted by an early sym_start
//   sym_cnt           completed-symbol counter, wraps 255->0
module cpe_pilot_accum #(
  parameter int N     = 64,
  parameter int Q     = 16,
  parameter int ACC_W = Q + 3,
  parameter int P0    = 7,
  parameter int P1    = 21,
  parameter int P2    = 43,
  parameter int P3    = 57
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_en,
  input  logic signed [Q-1:0]     in_r,
  input  logic signed [Q-1:0]     in_i,
  input  logic                    sym_start,
  output logic signed [ACC_W-1:0] cpe_r,
  output logic signed [ACC_W-1:0] cpe_i,
  output logic                    cpe_valid,
  output logic                    sync_err,
  output logic [7:0]              sym_cnt
);

  localparam int IDX_W = $clog2(N);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_r_q, acc_r_d, acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0]  cpe_r_q, cpe_r_d, cpe_i_q, cpe_i_d;
  logic                     valid_q, valid_d, err_q, err_d;
  logic [7:0]               cnt_q, cnt_d;

  logic signed [ACC_W-1:0]  ext_r, ext_i;
  logic signed [ACC_W-1:0]  add_r, add_i;    // contribution at the current idx
  logic signed [ACC_W-1:0]  first_r, first_i; // contribution when this sample restarts as bin 0

  function automatic logic is_pilot(input logic [IDX_W-1:0] k);
    return (k == IDX_W'(P0)) || (k == IDX_W'(P1)) ||
           (k == IDX_W'(P2)) || (k == IDX_W'(P3));
  endfunction

  assign ext_r   = {{(ACC_W-Q){in_r[Q-1]}}, in_r};
  assign ext_i   = {{(ACC_W-Q){in_i[Q-1]}}, in_i};
  assign add_r   = is_pilot(idx_q) ? ext_r : '0;
  assign add_i   = is_pilot(idx_q) ? ext_i : '0;
  assign first_r = is_pilot('0) ? ext_r : '0;
  assign first_i = is_pilot('0) ? ext_i : '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_r_d = acc_r_q;
    acc_i_d = acc_i_q;
    cpe_r_d = cpe_r_q;
    cpe_i_d = cpe_i_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_en && sym_start) begin
          state_d = ACCUM;
          idx_d   = IDX_W'(1);
          acc_r_d = first_r;
          acc_i_d = first_i;
        end
      end
      ACCUM: begin
        if (in_en) begin
          if (sym_start && (idx_q != '0)) begin
            // Early resync wins over completion, even at idx N-1.
            err_d   = 1'b1;
            idx_d   = IDX_W'(1);
            acc_r_d = first_r;
            acc_i_d = first_i;
          end else if (idx_q == IDX_W'(N-1)) begin
            cpe_r_d = acc_r_q + add_r;
            cpe_i_d = acc_i_q + add_i;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 8'd1;
            acc_r_d = '0;
            acc_i_d = '0;
            idx_d   = '0;
          end else begin
            // acc is already zero at idx 0, so bin 0 needs no special case here.
            acc_r_d = acc_r_q + add_r;
            acc_i_d = acc_i_q + add_i;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_r_q <= '0;
      acc_i_q <= '0;
      cpe_r_q <= '0;
      cpe_i_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_r_q <= acc_r_d;
      acc_i_q <= acc_i_d;
      cpe_r_q <= cpe_r_d;
      cpe_i_q <= cpe_i_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpe_r     = cpe_r_q;
  assign cpe_i     = cpe_i_q;
  assign cpe_valid = valid_q;
  assign sync_err  = err_q;
  assign sym_cnt   = cnt_q;

endmodule

// File: tb/tb_cpe_pilot_accum.sv
// Bench for cpe_pilot_accum: table of whole-symbol vectors, hand-written corner sequences,
// and a random phase, all cross-checked every cycle against a sample-queue reference model.
module tb_cpe_pilot_accum;

  localparam int N = 64, Q = 16, ACC_W = 19;
  localparam int P0 = 7, P1 = 21, P2 = 43, P3 = 57;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_en = 1'b0;
  logic                    sym_start = 1'b0;
  logic signed [Q-1:0]     in_r = '0, in_i = '0;
  logic signed [ACC_W-1:0] cpe_r, cpe_i;
  logic                    cpe_valid, sync_err;
  logic [7:0]              sym_cnt;

  cpe_pilot_accum #(.N(N), .Q(Q), .ACC_W(ACC_W), .P0(P0), .P1(P1), .P2(P2), .P3(P3)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_r(in_r), .in_i(in_i), .sym_start(sym_start),
    .cpe_r(cpe_r), .cpe_i(cpe_i), .cpe_valid(cpe_valid), .sync_err(sync_err), .sym_cnt(sym_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;

  // Reference model: keeps the samples of the current symbol in a queue and sums pilot positions.
  int m_r = 0, m_i = 0, m_cnt = 0;
  bit m_v = 0, m_e = 0, m_in = 0;
  int q_r[$], q_i[$];

  function automatic bit is_p(int k);
    return (k == P0) || (k == P1) || (k == P2) || (k == P3);
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic step(input bit r_, input bit en, input bit st, input int dr, input int di);
    rst = r_; in_en = en; sym_start = st; in_r = Q'(dr); in_i = Q'(di);
    @(posedge clk);
    cyc++;
    m_v = 0; m_e = 0;
    if (r_) begin
      m_r = 0; m_i = 0; m_cnt = 0; m_in = 0; q_r.delete(); q_i.delete();
    end else if (en) begin
      if (st) begin
        if (m_in && q_r.size() != 0) m_e = 1;
        q_r.delete(); q_i.delete(); m_in = 1;
      end
      if (m_in) begin
        q_r.push_back(dr); q_i.push_back(di);
        if (q_r.size() == N) begin
          m_r = q_r[P0] + q_r[P1] + q_r[P2] + q_r[P3];
          m_i = q_i[P0] + q_i[P1] + q_i[P2] + q_i[P3];
          m_v = 1; m_cnt = (m_cnt + 1) % 256;
          q_r.delete(); q_i.delete();
        end
      end
    end
    #1;
    total++;
    if (cpe_r !== ACC_W'(m_r) || cpe_i !== ACC_W'(m_i) || cpe_valid !== m_v ||
        sync_err !== m_e || sym_cnt !== 8'(m_cnt)) begin
      bad++;
      $display("FAIL cycle %0d: got cpe=(%0d,%0d) v=%b e=%b cnt=%0d, expected cpe=(%0d,%0d) v=%b e=%b cnt=%0d",
               cyc, cpe_r, cpe_i, cpe_valid, sync_err, sym_cnt, m_r, m_i, m_v, m_e, m_cnt);
    end
  endtask

  // Sends bins lo..hi; sym_start accompanies the first of them when st_first is set.
  task automatic send_bins(input int lo, input int hi, input bit st_first,
                           input int pr, input int pi, input int or_, input int oi, input int gaps);
    for (int k = lo; k <= hi; k++) begin
      if (gaps > 0) repeat ($urandom_range(0, gaps)) step(0, 0, 0, $urandom_range(0, 999), 0);
      step(0, 1, st_first && (k == lo), is_p(k) ? pr : or_, is_p(k) ? pi : oi);
    end
  endtask

  typedef struct {
    bit rst_before;
    int pr, pi, or_, oi, gaps;
    int er, ei, ecnt;
  } vec_t;

  vec_t vecs[5];
  int   end_cyc[5];

  initial begin
    vecs[0] = '{1, 100, -50, 1000, 1000, 0, 400, -200, 1};
    vecs[1] = '{1, -32768, 32767, 1000, 1000, 0, -131072, 131068, 1};
    vecs[2] = '{0, 5, 5, 1000, 1000, 0, 20, 20, 2};
    vecs[3] = '{1, 100, -50, 1000, 1000, 5, 400, -200, 1};
    vecs[4] = '{0, 10, 0, -7, 3, 2, 40, 0, 2};

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_cpe_r", int'(cpe_r), 0);
    chk("reset_valid", int'(cpe_valid), 0);
    chk("reset_cnt", int'(sym_cnt), 0);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].rst_before) step(1, 0, 0, 0, 0);
      send_bins(0, N-1, 1, vecs[v].pr, vecs[v].pi, vecs[v].or_, vecs[v].oi, vecs[v].gaps);
      end_cyc[v] = cyc;
      chk($sformatf("vec%0d_valid", v), int'(cpe_valid), 1);
      chk($sformatf("vec%0d_cpe_r", v), int'(cpe_r), vecs[v].er);
      chk($sformatf("vec%0d_cpe_i", v), int'(cpe_i), vecs[v].ei);
      chk($sformatf("vec%0d_cnt", v), int'(sym_cnt), vecs[v].ecnt);
    end
    chk("b2b_spacing", end_cyc[2] - end_cyc[1], 64);
    step(0, 0, 0, 0, 0);
    chk("pulse_width", int'(cpe_valid), 0);
    chk("hold_cpe_r", int'(cpe_r), 40);

    // Early resync at idx 30.
    step(1, 0, 0, 0, 0);
    send_bins(0, 29, 1, 77, 77, 1000, 1000, 0);
    step(0, 1, 1, 1000, 1000);
    chk("resync_err", int'(sync_err), 1);
    chk("resync_no_valid", int'(cpe_valid), 0);
    send_bins(1, N-1, 0, 10, 0, 1000, 1000, 0);
    chk("resync_cpe_r", int'(cpe_r), 40);
    chk("resync_cnt", int'(sym_cnt), 1);

    // Resync coincident with the last bin aborts instead of completing.
    send_bins(0, N-2, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("lastbin_err", int'(sync_err), 1);
    chk("lastbin_cnt", int'(sym_cnt), 1);
    send_bins(1, N-1, 0, 2, 2, 0, 0, 0);
    chk("lastbin_next_cpe", int'(cpe_r), 8);

    // Samples before any sym_start are dropped.
    step(1, 0, 0, 0, 0);
    repeat (20) step(0, 1, 0, 500, 500);
    chk("presync_cnt", int'(sym_cnt), 0);
    send_bins(0, N-1, 1, 3, -4, 9, 9, 0);
    chk("presync_cpe_r", int'(cpe_r), 12);
    chk("presync_cpe_i", int'(cpe_i), -16);

    // Reset in the middle of a symbol, after one completed symbol.
    send_bins(40, N-1, 1, 0, 0, 0, 0, 0); // bins relabelled; sends a short run to realign
    send_bins(0, N-1, 1, 6, 6, 1, 1, 0);
    send_bins(0, 39, 1, 6, 6, 1, 1, 0);
    step(1, 1, 0, 1, 1);
    chk("midrst_cpe_r", int'(cpe_r), 0);
    chk("midrst_cnt", int'(sym_cnt), 0);
    chk("midrst_valid", int'(cpe_valid), 0);
    repeat (70) step(0, 1, 0, 100, 100);
    chk("midrst_ignored_cnt", int'(sym_cnt), 0);
    send_bins(0, N-1, 1, -1, 2, 50, 50, 0);
    chk("midrst_after_cpe_i", int'(cpe_i), 8);

    // Random phase against the model.
    step(1, 0, 0, 0, 0);
    for (int n = 0; n < 6000; n++) begin
      step($urandom_range(0, 1999) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0,
           int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpe_pilot_accum.md
Name: cpe_pilot_accum

Overview:
- Sits directly downstream of the conjugate complex multiplier in the receiver chain.
- Consumes its per-subcarrier products (rx × conj(ref)) in FFT-bin order, one symbol of N bins at a time.
- Sums the products at the four pilot bins to form the common-phase-error (CPE) vector of each OFDM symbol.
- Presents that sum with a one-cycle valid pulse for the phase-tracking stage.

Parameters:
- N, 64, subcarriers per symbol; power of two, ≥ 8.
- Q, 16, width of signed input products (Q_int + Q_dec fixed point).
- ACC_W, Q+3, accumulator/output width: 4 pilots → +2 bits, +1 guard.
- P0, 7, pilot bin index 0.
- P1, 21, pilot bin index 1.
- P2, 43, pilot bin index 2.
- P3, 57, pilot bin index 3. All Pk are distinct and < N.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_en  in  1  product valid; driven from the multiplier's delayed data enable.
- in_r  in  Q  signed real product.
- in_i  in  Q  signed imaginary product.
- sym_start  in  1  marks the in_en sample that is bin 0 of a symbol; ignored when in_en=0.
- cpe_r  out  ACC_W  signed real pilot sum.
- cpe_i  out  ACC_W  signed imaginary pilot sum.
- cpe_valid  out  1  one-cycle pulse: cpe_r/cpe_i updated.
- sync_err  out  1  one-cycle pulse: symbol aborted by an early sym_start.
- sym_cnt  out  8  completed-symbol count; wraps 255→0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; idx=0; acc_r=acc_i=0.
  - cpe_r=cpe_i=0, cpe_valid=0, sync_err=0, sym_cnt=0.
  - A reset mid-symbol discards the partial sum; no pulse is generated.
- States are IDLE and ACCUM.
- IDLE:
  - in_en samples are dropped until in_en=1 and sym_start=1.
  - That sample is taken as idx 0 and the state moves to ACCUM.
- ACCUM: each in_en=1 sample is processed at the current idx. in_en=0 cycles freeze idx and acc (gaps of any length are allowed).
- Pilot test: a sample is a pilot iff idx ∈ {P0..P3}. Pilot samples are sign-extended to ACC_W and added to acc; non-pilot samples add nothing.
  - For the bin-0 sample this means acc is loaded with 0 if bin 0 is not a pilot, or with the extended sample if it is.
- idx increments by 1 per accepted sample.
- End of symbol: when the accepted sample has idx=N-1:
  - next cycle: cpe_r/cpe_i = final sum (including that sample if it is a pilot), cpe_valid=1, sym_cnt+1.
  - acc is cleared; idx=0; state stays ACCUM so back-to-back symbols need no gap.
  - Latency: cpe_valid rises exactly 1 clk after the last bin's in_en.
- sym_start=1 with in_en=1 at idx=0 in ACCUM is normal alignment; no error.
- sym_start=1 with in_en=1 at idx≠0 (early resync):
  - The partial symbol is dropped: no cpe_valid, sym_cnt unchanged.
  - sync_err pulses the next cycle.
  - The current sample becomes idx 0 of a new symbol, with acc reloaded per the pilot rule.
- sym_start coincident with idx=N-1 is an early resync: the abort rule takes priority over symbol completion.
- cpe_r/cpe_i hold their value between cpe_valid pulses.
- Arithmetic is two's complement with no saturation; ACC_W guarantees no overflow for 4 pilots.
- cpe_valid and sync_err are never asserted in the same cycle.

Test Plan:
- Reset, then 64 samples with sym_start on the first. Pilots at bins 7/21/43/57 = (100,-50); all other bins = (1000,1000). → 1 clk after the last sample: cpe=(400,-200), cpe_valid=1 for one cycle, sym_cnt=1.
- Two back-to-back symbols, no gap. Pilots (-32768,32767) then (5,5). → cpe=(-131072,131068), then (20,20); two pulses exactly 64 clk apart; sym_cnt=2.
- Same as the first symbol but with random in_en=0 gaps (up to 5 cycles) inserted. → identical cpe=(400,-200); pulse 1 clk after the last valid sample.
- Start a symbol; at idx=30 assert sym_start, then send a full 64-sample symbol with pilots (10,0). → sync_err pulse at idx 30+1 clk; no cpe_valid for the aborted symbol; then cpe=(40,0), sym_cnt=1.
- 20 in_en samples before any sym_start. → ignored (state stays IDLE); the following aligned symbol gives the correct sum.
- Assert rst for 1 cycle at idx=40. → all outputs 0 the next cycle; no pulse; samples are ignored until the next sym_start.
